// File: rtl/window_7x7_frame_sequencer.sv
// rtl/window_7x7_frame_sequencer.sv - column/row sequencing and window-valid flags for a 7x7 window buffer
module window_7x7_frame_sequencer #(
    parameter int COLS  = 640,
    parameter int ROWS  = 480,
    parameter int KSIZE = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_i,
    output logic        count_en,
    output logic        done_o,
    output logic        progress_done_o,
    output logic [11:0] win_col_o,
    output logic [11:0] win_row_o,
    output logic        busy_o,
    output logic        drop_o
);

    localparam logic [11:0] COL_LAST = 12'(COLS - 1);
    localparam logic [11:0] ROW_LAST = 12'(ROWS - 1);
    localparam logic [11:0] FILL     = 12'(KSIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [11:0] col_cnt;
    logic [11:0] row_cnt;
    logic        last_col;

    assign last_col = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // count_en is gated by rst so every output reads 0 while reset is held
    always_comb begin
        state_d         = state_q;
        count_en        = 1'b0;
        busy_o          = 1'b0;
        progress_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                count_en = done_i & rst;
                if (done_i) state_d = RUN;
            end
            RUN: begin
                count_en = done_i & rst;
                busy_o   = 1'b1;
                if (done_i && last_col) state_d = DONE;
            end
            DONE: begin
                busy_o          = 1'b1;
                progress_done_o = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window flags lag acceptance by one cycle to line up with the datapath tap registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            done_o    <= 1'b0;
            win_col_o <= '0;
            win_row_o <= '0;
            drop_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (count_en) begin
                if (col_cnt >= FILL) begin
                    done_o    <= 1'b1;
                    win_col_o <= col_cnt - FILL;
                    win_row_o <= row_cnt;
                end
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= '0;
                end else if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 12'd1;
                end else begin
                    col_cnt <= col_cnt + 12'd1;
                end
            end
            if (state_q == DONE && done_i) drop_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_window_7x7_frame_sequencer.sv
// tb/tb_window_7x7_frame_sequencer.sv - directed bench for window_7x7_frame_sequencer
module tb_window_7x7_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_a, done_b;
    logic        a_ce, a_done, a_prog, a_busy, a_drop;
    logic [11:0] a_col, a_row;
    logic        b_ce, b_done, b_prog, b_busy, b_drop;
    logic [11:0] b_col, b_row;

    int checks = 0;
    int errors = 0;
    int ce_n, done_n, prog_n, prog_at, prog_coinc, gap_bad, b_done_n;
    logic prev_ce;
    int cols[$];
    int rows[$];

    always #5 clk = ~clk;

    window_7x7_frame_sequencer #(.COLS(10), .ROWS(3)) dut_a (
        .clk(clk), .rst(rst), .done_i(done_a), .count_en(a_ce), .done_o(a_done),
        .progress_done_o(a_prog), .win_col_o(a_col), .win_row_o(a_row),
        .busy_o(a_busy), .drop_o(a_drop)
    );

    window_7x7_frame_sequencer #(.COLS(7), .ROWS(1)) dut_b (
        .clk(clk), .rst(rst), .done_i(done_b), .count_en(b_ce), .done_o(b_done),
        .progress_done_o(b_prog), .win_col_o(b_col), .win_row_o(b_row),
        .busy_o(b_busy), .drop_o(b_drop)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        ce_n = 0; done_n = 0; prog_n = 0; prog_at = -1; prog_coinc = 0; gap_bad = 0;
        prev_ce = 1'b0;
        cols.delete();
        rows.delete();
    endtask

    // Drive one cycle on the falling edge; registered outputs seen here reflect the previous cycle
    task automatic cycle(input logic d);
        @(negedge clk);
        done_a = d;
        #1;
        if (a_ce) ce_n++;
        if (a_done) begin
            done_n++;
            cols.push_back(int'(a_col));
            rows.push_back(int'(a_row));
            if (!prev_ce) gap_bad++;
        end
        if (a_prog) begin
            prog_n++;
            prog_at    = done_n;
            prog_coinc = int'(a_done);
        end
        prev_ce = a_ce;
    endtask

    task automatic check_coords(input string tag, input int total);
        check({tag, " window count"}, cols.size(), total);
        for (int i = 0; i < cols.size() && i < total; i++) begin
            check($sformatf("%s col[%0d]", tag, i), cols[i], i % 4);
            check($sformatf("%s row[%0d]", tag, i), rows[i], (i / 4) % 3);
        end
    endtask

    initial begin
        rst = 1'b0; done_a = 1'b0; done_b = 1'b0;
        #12;
        check("reset count_en", int'(a_ce), 0);
        check("reset done_o", int'(a_done), 0);
        check("reset progress", int'(a_prog), 0);
        check("reset win_col", int'(a_col), 0);
        check("reset win_row", int'(a_row), 0);
        check("reset busy", int'(a_busy), 0);
        check("reset drop", int'(a_drop), 0);
        @(negedge clk);
        rst = 1'b1;

        // continuous strobes, one frame
        clear_obs();
        for (int i = 0; i < 30; i++) cycle(1'b1);
        cycle(1'b0);
        check("cont busy in DONE", int'(a_busy), 1);
        cycle(1'b0);
        check("cont busy after DONE", int'(a_busy), 0);
        check("cont count_en cycles", ce_n, 30);
        check_coords("cont", 12);
        check("cont progress pulses", prog_n, 1);
        check("cont progress at 12th", prog_at, 12);
        check("cont progress with done_o", prog_coinc, 1);

        // alternate-cycle strobes
        clear_obs();
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1);
            cycle(1'b0);
        end
        cycle(1'b0);
        check_coords("alt", 12);
        check("alt done_o after gap", gap_bad, 0);
        check("alt progress pulses", prog_n, 1);
        check("alt progress at 12th", prog_at, 12);
        check("alt drop", int'(a_drop), 0);

        // 31st strobe lands in DONE
        clear_obs();
        for (int i = 0; i < 31; i++) cycle(1'b1);
        cycle(1'b0);
        check("over drop set", int'(a_drop), 1);
        cycle(1'b0);
        check("over drop sticky", int'(a_drop), 1);
        check("over count_en cycles", ce_n, 30);
        check("over windows", done_n, 12);

        // reset in the middle of row 1
        for (int i = 0; i < 15; i++) cycle(1'b1);
        @(negedge clk);
        done_a = 1'b0;
        #1;
        check("pre-reset busy", int'(a_busy), 1);
        check("pre-reset win_col", int'(a_col), 3);
        rst = 1'b0;
        #1;
        check("async busy", int'(a_busy), 0);
        check("async win_col", int'(a_col), 0);
        check("async drop", int'(a_drop), 0);
        check("async done_o", int'(a_done), 0);
        check("async count_en", int'(a_ce), 0);
        #1;
        rst = 1'b1;
        clear_obs();
        for (int i = 0; i < 30; i++) cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        check_coords("post-reset", 12);
        check("post-reset progress", prog_n, 1);

        // two frames back to back
        clear_obs();
        for (int i = 0; i < 30; i++) cycle(1'b1);
        cycle(1'b0);
        for (int i = 0; i < 30; i++) cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        check_coords("b2b", 24);
        check("b2b progress pulses", prog_n, 2);
        check("b2b drop", int'(a_drop), 0);
        check("b2b done_o after gap", gap_bad, 0);

        // minimum frame on the 7x1 instance
        b_done_n = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            done_b = 1'b1;
            #1;
            if (b_done) b_done_n++;
            check($sformatf("min count_en %0d", i), int'(b_ce), 1);
        end
        @(negedge clk);
        done_b = 1'b0;
        #1;
        check("min early done_o", b_done_n, 0);
        check("min done_o", int'(b_done), 1);
        check("min progress", int'(b_prog), 1);
        check("min win_col", int'(b_col), 0);
        check("min win_row", int'(b_row), 0);
        @(negedge clk);
        #1;
        check("min done_o after", int'(b_done), 0);
        check("min busy after", int'(b_busy), 0);
        check("min drop", int'(b_drop), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_7x7_frame_sequencer.md
Name: window_7x7_frame_sequencer

Overview:
- Sequencing controller for the 7x7 window-buffer datapath (seven 8-bit row taps in, 49 window taps out).
- Counts accepted column strobes across one frame and drives the datapath shift enable.
- Flags which shifts yield a fully populated 7x7 window, reports window coordinates, and pulses once at end of frame.
- Sits between the 7-row line buffer (source of done_i) and the downstream 7x7 filter stage.

Parameters:
- COLS, 640, frame width in pixels; legal range 7..4095.
- ROWS, 480, number of 7-row column strobe rows per frame, equal to output window rows; legal range 1..4095.
- KSIZE, 7, window size; fixed at 7, not to be overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- done_i  input  1  one 7-pixel column valid on the datapath inputs this cycle.
- count_en  output  1  shift enable to the window datapath.
- done_o  output  1  window taps hold a complete 7x7 window this cycle.
- progress_done_o  output  1  one-cycle pulse: last window of the frame is on the taps.
- win_col_o  output  12  column index of the current window (0..COLS-7), valid when done_o=1.
- win_row_o  output  12  row index of the current window (0..ROWS-1), valid when done_o=1.
- busy_o  output  1  a frame is in progress.
- drop_o  output  1  sticky: done_i arrived while in DONE state; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; col_cnt=0; row_cnt=0.
  - All outputs are 0.
- count_en is combinational and equals done_i in states IDLE and RUN. It is 0 in DONE.
- Column acceptance: a column is accepted when count_en=1.
- col_cnt:
  - Increments on each accepted column.
  - Wraps to 0 after COLS-1.
  - On that wrap, row_cnt increments.
- Output timing: done_o, win_col_o and win_row_o are registered.
  - They assert the cycle after an accepted column whose col_cnt (pre-increment) is at least 6. This aligns them with the datapath registers.
  - win_col_o = col_cnt-6 and win_row_o = row_cnt, both sampled at acceptance.
  - When done_o=0, win_col_o and win_row_o hold their last values.
- Windows per frame: (COLS-6) per row and (COLS-6)*ROWS in total.
  - The first 6 accepted columns of each row never produce done_o. This is the refill after a row wrap.
- FSM states and transitions:
  - IDLE (busy_o=0): the first accepted done_i moves to RUN, and that column is counted.
  - RUN (busy_o=1): counts columns.
    - The last column (col_cnt=COLS-1 and row_cnt=ROWS-1) moves to DONE.
    - On that move, col_cnt and row_cnt clear to 0.
  - DONE (busy_o=1, one cycle):
    - progress_done_o=1, coincident with the final done_o.
    - Unconditional return to IDLE.
    - If done_i=1 in DONE, the column is not accepted (count_en=0) and drop_o sets.
- done_i gaps (done_i=0 for any number of cycles) inside RUN:
  - Counters hold.
  - done_o=0 the cycle after each gap cycle.
- Back-to-back frames: a done_i in the cycle after DONE (state=IDLE) starts the next frame with no further penalty.
- Reset mid-frame: counters and FSM return to IDLE immediately. Any partially shifted window is never flagged valid.
- Counter widths are 12 bits. There is no overflow condition within the legal parameter range.

Test Plan:
- COLS=10, ROWS=3, done_i held high for 30 cycles:
  - count_en high for 30 cycles.
  - Exactly 12 done_o pulses, in 3 bursts of 4, with win_col_o 0..3 in each burst.
  - win_row_o 0, 1, 2 across the bursts.
  - progress_done_o high only in the cycle of the 12th done_o; busy_o falls the cycle after.
- Same configuration, done_i asserted on alternate cycles:
  - Same 12 windows with identical coordinates.
  - done_o only in the cycles following accepted columns.
- done_i left high for 31 cycles: the 31st strobe hits DONE, so count_en=0, drop_o=1 sticky, and no extra done_o.
- Assert rst low after 15 accepted columns (mid row 1):
  - All outputs go to 0 asynchronously.
  - A following 30-column frame yields 12 windows starting at win_row_o=0, win_col_o=0.
- Two frames back-to-back (done_i high for 30 cycles, low for 1 cycle in DONE, high for 30 more): 24 done_o total, two progress_done_o pulses, drop_o remains 0.
- COLS=7, ROWS=1: 7 strobes produce a single done_o with win_col_o=0, win_row_o=0, coincident with progress_done_o.
